// File: rtl/parking_pkg.sv
// Shared constants and types for the parking-sensor input conditioner.
// Channel indices fix which debounce slice serves which board pin.
package parking_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 400000;

    localparam int CH_ENTRY = 0;
    localparam int CH_EXIT  = 1;
    localparam int CH_SW0   = 2;
    localparam int CH_SW1   = 3;
    localparam int NUM_CH   = 4;

    // Per-channel result: accepted level plus the one-cycle rise flag.
    typedef struct packed {
        logic level;
        logic rise;
    } ch_status_t;

endpackage

// File: rtl/parking_sensor_conditioner_if.sv
// Raw sensor pins in, clean levels and arbitrated event pulses out.
// No handshake: the consumer samples every clk, the pins cannot be stalled.
interface parking_sensor_conditioner_if;

    logic       entry_raw;
    logic       exit_raw;
    logic [1:0] switch_raw;

    logic       entry_level;
    logic       exit_level;
    logic [1:0] switch_stable;
    logic       entry_pulse;
    logic       exit_pulse;

    // Board/stimulus side: drives the pins, observes the conditioned results.
    modport master (
        output entry_raw, exit_raw, switch_raw,
        input  entry_level, exit_level, switch_stable, entry_pulse, exit_pulse
    );

    // Conditioner side.
    modport slave (
        input  entry_raw, exit_raw, switch_raw,
        output entry_level, exit_level, switch_stable, entry_pulse, exit_pulse
    );

endinterface

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser, debounce counter, stable level, rise flag.
// Latency 2 + DEBOUNCE_CYCLES edges from a held raw change; no backpressure.
module debounce_channel
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw,
    output ch_status_t status
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             st_q,    st_d;
    logic             rise_q,  rise_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        st_d    = st_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        // Any sample that agrees with the stable value drops the partial count.
        if (sync2_q != st_q) begin
            if (cnt_q == CNT_MAX) begin
                st_d   = sync2_q;
                rise_d = sync2_q;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            st_q    <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            st_q    <= st_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign status.level = st_q;
    assign status.rise  = rise_q;

endmodule

// File: rtl/parking_sensor_conditioner.sv
// Debounces entry/exit/switch pins and arbitrates entry vs exit pulses (exit first).
// Pulses appear with the level, entry deferred 1 cycle on a tie; no backpressure.
module parking_sensor_conditioner
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    parking_sensor_conditioner_if.slave  bus
);

    logic [NUM_CH-1:0] raw_vec;
    ch_status_t        status [NUM_CH];

    logic pending_q, pending_d;
    logic entry_pulse_w;
    logic exit_pulse_w;
    logic sw_rise_unused;

    assign raw_vec[CH_ENTRY] = bus.entry_raw;
    assign raw_vec[CH_EXIT]  = bus.exit_raw;
    assign raw_vec[CH_SW0]   = bus.switch_raw[0];
    assign raw_vec[CH_SW1]   = bus.switch_raw[1];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_vec[ch]),
            .status (status[ch])
        );
    end

    // Exit wins a tie; the losing entry event is parked for exactly one cycle.
    // Pulses are gated rise flops only, so nothing combinational reaches them from the pins.
    always_comb begin
        exit_pulse_w  = status[CH_EXIT].rise;
        entry_pulse_w = pending_q | (status[CH_ENTRY].rise & ~status[CH_EXIT].rise);
        pending_d     = status[CH_ENTRY].rise & status[CH_EXIT].rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.entry_level   = status[CH_ENTRY].level;
    assign bus.exit_level    = status[CH_EXIT].level;
    assign bus.switch_stable = {status[CH_SW1].level, status[CH_SW0].level};
    assign bus.entry_pulse   = entry_pulse_w;
    assign bus.exit_pulse    = exit_pulse_w;

    assign sw_rise_unused = status[CH_SW0].rise | status[CH_SW1].rise;

endmodule
